// File: rtl/vmask_reduce.sv
// vmask_reduce: two-stage vector mask reduction (vcpop.m population count, optional vfirst.m find-first).
// Define VMASK_REDUCE_FIRST_EN to build find-first mode; without it in_mode is ignored and popcount is always performed.
module vmask_reduce #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int DATA_WIDTH_BITS = $clog2(REQ_DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_start,
    input  logic                       in_last,
    input  logic                       in_mode,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic [REQ_DATA_WIDTH-1:0]  in_en,
    input  logic [RESP_DATA_WIDTH-1:0] in_count,
    output logic                       out_valid,
    output logic [RESP_DATA_WIDTH-1:0] out_vec
);

    localparam logic [RESP_DATA_WIDTH-1:0] RESP_ZERO = {RESP_DATA_WIDTH{1'b0}};
    localparam logic [REQ_DATA_WIDTH-1:0]  REQ_ZERO  = {REQ_DATA_WIDTH{1'b0}};

    function automatic logic [DATA_WIDTH_BITS:0] popcount(input logic [REQ_DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH_BITS:0] c;
        c = {(DATA_WIDTH_BITS+1){1'b0}};
        for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
            c = c + {{DATA_WIDTH_BITS{1'b0}}, v[i]};
        end
        return c;
    endfunction

`ifdef VMASK_REDUCE_FIRST_EN
    localparam logic [RESP_DATA_WIDTH-1:0] RESP_ONES = {RESP_DATA_WIDTH{1'b1}};
    localparam logic [RESP_DATA_WIDTH-1:0] RESP_ONE  = RESP_DATA_WIDTH'(1);
    localparam logic [RESP_DATA_WIDTH-1:0] BEAT_BITS = RESP_DATA_WIDTH'(REQ_DATA_WIDTH);

    // Scanning from the top leaves the lowest set position as the final value.
    function automatic logic [DATA_WIDTH_BITS-1:0] lowest_set(input logic [REQ_DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH_BITS-1:0] idx;
        idx = {DATA_WIDTH_BITS{1'b0}};
        for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = DATA_WIDTH_BITS'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction
`endif

    logic                       s1_valid_r;
    logic                       s1_start_r;
    logic                       s1_last_r;
    logic [REQ_DATA_WIDTH-1:0]  s1_mask_r;
    logic [RESP_DATA_WIDTH-1:0] s1_count_r;
    logic [RESP_DATA_WIDTH-1:0] acc_r;
    logic                       out_valid_r;
    logic [RESP_DATA_WIDTH-1:0] out_vec_r;

    logic [DATA_WIDTH_BITS:0]   pop_s;
    logic [RESP_DATA_WIDTH-1:0] acc_next_s;
    logic [RESP_DATA_WIDTH-1:0] result_s;

`ifdef VMASK_REDUCE_FIRST_EN
    logic                       s1_mode_r;
    logic                       mode_r;
    logic [RESP_DATA_WIDTH-1:0] beat_idx_r;
    logic                       found_r;
    logic [RESP_DATA_WIDTH-1:0] first_r;

    logic                       mode_cur_s;
    logic [RESP_DATA_WIDTH-1:0] idx_cur_s;
    logic                       found_cur_s;
    logic [RESP_DATA_WIDTH-1:0] first_cur_s;
    logic                       found_next_s;
    logic [RESP_DATA_WIDTH-1:0] first_next_s;
`else
    logic unused_mode_s;
    assign unused_mode_s = in_mode;
`endif

    // Stage 1: capture the active mask bits and beat framing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_start_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_mask_r  <= REQ_ZERO;
            s1_count_r <= RESP_ZERO;
`ifdef VMASK_REDUCE_FIRST_EN
            s1_mode_r  <= 1'b0;
`endif
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_start_r <= in_start;
                s1_last_r  <= in_last;
                s1_mask_r  <= in_m0 & in_en;
                s1_count_r <= in_start ? in_count : s1_count_r;
`ifdef VMASK_REDUCE_FIRST_EN
                s1_mode_r  <= in_mode;
`endif
            end else begin
                s1_start_r <= s1_start_r;
                s1_last_r  <= s1_last_r;
                s1_mask_r  <= s1_mask_r;
                s1_count_r <= s1_count_r;
            end
        end
    end

    // Stage 2 next-state: a start beat restarts every per-operation tracker.
    always_comb begin
        pop_s = popcount(s1_mask_r);
        if (s1_start_r) begin
            acc_next_s = s1_count_r + RESP_DATA_WIDTH'(pop_s);
        end else begin
            acc_next_s = acc_r + RESP_DATA_WIDTH'(pop_s);
        end
`ifdef VMASK_REDUCE_FIRST_EN
        if (s1_start_r) begin
            mode_cur_s  = s1_mode_r;
            idx_cur_s   = RESP_ZERO;
            found_cur_s = 1'b0;
            first_cur_s = RESP_ZERO;
        end else begin
            mode_cur_s  = mode_r;
            idx_cur_s   = beat_idx_r;
            found_cur_s = found_r;
            first_cur_s = first_r;
        end
        if (!found_cur_s && (s1_mask_r != REQ_ZERO)) begin
            found_next_s = 1'b1;
            first_next_s = idx_cur_s * BEAT_BITS + RESP_DATA_WIDTH'(lowest_set(s1_mask_r));
        end else begin
            found_next_s = found_cur_s;
            first_next_s = first_cur_s;
        end
        if (mode_cur_s) begin
            result_s = found_next_s ? first_next_s : RESP_ONES;
        end else begin
            result_s = acc_next_s;
        end
`else
        result_s = acc_next_s;
`endif
    end

    // Stage 2 state and the registered result pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= RESP_ZERO;
            out_valid_r <= 1'b0;
            out_vec_r   <= RESP_ZERO;
`ifdef VMASK_REDUCE_FIRST_EN
            mode_r      <= 1'b0;
            beat_idx_r  <= RESP_ZERO;
            found_r     <= 1'b0;
            first_r     <= RESP_ZERO;
`endif
        end else if (s1_valid_r) begin
            acc_r       <= acc_next_s;
            out_valid_r <= s1_last_r;
            out_vec_r   <= s1_last_r ? result_s : out_vec_r;
`ifdef VMASK_REDUCE_FIRST_EN
            mode_r      <= mode_cur_s;
            beat_idx_r  <= idx_cur_s + RESP_ONE;
            found_r     <= found_next_s;
            first_r     <= first_next_s;
`endif
        end else begin
            acc_r       <= acc_r;
            out_valid_r <= 1'b0;
            out_vec_r   <= out_vec_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_vec   = out_vec_r;

endmodule

// File: doc/vmask_reduce.md
VMASK_REDUCE -- requirements
Module: vmask_reduce

Interface
REQ-001 SHALL have parameter REQ_DATA_WIDTH, default 64: mask bits per input beat.
REQ-002 SHALL have parameter RESP_DATA_WIDTH, default 64: result and accumulator width.
REQ-003 SHALL have parameter DATA_WIDTH_BITS, default $clog2(REQ_DATA_WIDTH): bit-index width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  beat present this cycle.
REQ-007 SHALL have port in_start  input  1  first beat of an operation, qualified by in_valid.
REQ-008 SHALL have port in_last  input  1  final beat of an operation, qualified by in_valid.
REQ-009 SHALL have port in_mode  input  1  0 = population count (vcpop.m), 1 = find-first (vfirst.m).
REQ-010 SHALL have port in_m0  input  REQ_DATA_WIDTH  mask source bits.
REQ-011 SHALL have port in_en  input  REQ_DATA_WIDTH  per-bit active enable (vl/vm tail); inactive bits count as 0.
REQ-012 SHALL have port in_count  input  RESP_DATA_WIDTH  initial accumulator offset, sampled on start beat, popcount mode only.
REQ-013 SHALL have port out_valid  output  1  one-cycle result pulse.
REQ-014 SHALL have port out_vec  output  RESP_DATA_WIDTH  result, held until next result.

Function
REQ-015 SHALL register in_m0 & in_en, in_valid, in_start, in_last and in_mode in stage 1 on the edge sampling the beat.
REQ-016 SHALL compute stage-1 popcount in DATA_WIDTH_BITS+1 bits so an all-ones beat counts REQ_DATA_WIDTH without overflow.
REQ-017 SHALL, on a stage-1 valid beat with start set, load acc = in_count + popcount; otherwise acc = acc + popcount; addition wraps modulo 2^RESP_DATA_WIDTH.
REQ-018 SHALL keep a beat index, cleared to 0 on a start beat and incremented after every valid beat, wrapping modulo 2^RESP_DATA_WIDTH.
REQ-019 SHALL, in find-first mode, record beat_idx*REQ_DATA_WIDTH + index of lowest set active bit on the first beat containing one, and ignore later set bits.
REQ-020 SHALL return all-ones in find-first mode when no active bit was set across the operation.
REQ-021 SHALL assert out_valid for exactly one cycle, two cycles after the in_last beat is sampled (latency 2), with out_vec valid that cycle.
REQ-022 SHALL accept one beat per cycle with no backpressure; in_valid low cycles are bubbles that leave all state unchanged.
REQ-023 SHALL treat in_start and in_last on the same beat as a complete single-beat operation.
REQ-024 SHALL, on in_start while an operation is open, abandon it without out_valid and start anew.
REQ-025 SHALL treat a beat without a preceding start as continuing from current acc and beat index.
REQ-026 SHALL allow a new start beat the cycle after a last beat with no bubble; back-to-back results pulse in consecutive cycles.
REQ-027 SHALL latch in_mode on the start beat; in_mode on later beats is ignored.

Reset
REQ-028 SHALL, while rst is low, clear asynchronously all pipeline valids, acc, beat index, found flag, out_valid and out_vec to 0.
REQ-029 SHALL discard any in-flight operation on reset; no out_valid pulse for it after release.
REQ-030 SHALL accept a start beat in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with VMASK_REDUCE_FIRST_EN defined, implement find-first mode per REQ-018..REQ-020.
REQ-032 SHALL, without VMASK_REDUCE_FIRST_EN, omit find-first logic and beat index, ignore in_mode and always perform popcount.

Verification
REQ-033 SHALL cover: single beat start+last, in_m0=all ones, in_en=all ones, in_count=5 -> out_valid 2 cycles later, out_vec=69.
REQ-034 SHALL cover: three beats with popcounts 3, 0, 64, bubble between beats 2 and 3, in_count=0 -> single pulse, out_vec=67.
REQ-035 SHALL cover: find-first, beat 0 mask 0, beat 1 in_m0=0x10, in_en=0x0F then next op in_en=0xFF -> first op out_vec=all-ones, second op (same data, two beats) out_vec=68.
REQ-036 SHALL cover: back-to-back single-beat ops popcount 1 then 2 -> out_valid high two consecutive cycles, out_vec 1 then 2.
REQ-037 SHALL cover: rst low one cycle after in_last beat -> no out_valid, out_vec=0; start after release -> correct result.
REQ-038 SHALL cover: in_start mid-operation after two beats -> no pulse for abandoned op; result reflects only new op.
